// File: rtl/dense_weight_update_pkg.sv
// Shared defaults, saturation limits and FSM state encoding for the dense weight-update stage.
package dense_pkg;
  localparam int DATA_SIZE = 16;
  localparam int FRAC_BITS = 8;
  localparam logic signed [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam int BP_EN_BIT = 0;

  typedef enum logic [2:0] {IDLE, ERR, STEP, UPD, DONE} state_t;
endpackage

// File: rtl/dense_weight_update_fixed_mul_sat.sv
// Signed fixed-point multiply, arithmetic shift by frac_bits, saturate to data_size.
// Latency: combinational.
// Backpressure: none, pure function of its operands.
module fixed_mul_sat
  import dense_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int frac_bits = FRAC_BITS
) (
  input  logic signed [data_size-1:0] a,
  input  logic signed [data_size-1:0] b,
  output logic signed [data_size-1:0] p
);
  logic signed [2*data_size-1:0] prod;
  logic signed [2*data_size-1:0] shifted;
  logic                          ovf;

  always_comb begin
    prod    = (2*data_size)'(a) * (2*data_size)'(b);
    shifted = prod >>> frac_bits;
    // Result fits only if everything above the kept field is pure sign extension.
    ovf = (shifted[2*data_size-1:data_size-1] != {(data_size+1){shifted[2*data_size-1]}});
    if (ovf)
      p = shifted[2*data_size-1] ? {1'b1, {(data_size-1){1'b0}}} : {1'b0, {(data_size-1){1'b1}}};
    else
      p = shifted[data_size-1:0];
  end
endmodule

// File: rtl/dense_weight_update.sv
// Per-lane w -= lr*(y-p)*x using one shared saturating multiplier, lane by lane.
// Latency: 3*size+1 cycles when enabled, 1 cycle when bypassed.
// Backpressure: holds result in DONE until out_ready; in_ready only in IDLE.
module dense_weight_update
  import dense_pkg::*;
#(
  parameter int size                   = 3,
  parameter int data_size              = DATA_SIZE,
  parameter int frac_bits              = FRAC_BITS,
  parameter int learning_rate_size     = 16,
  parameter int backprop_controll_size = 66
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [data_size*size-1:0]         w,
  input  logic [data_size*size-1:0]         x,
  input  logic [data_size*size-1:0]         y,
  input  logic [data_size*size-1:0]         predict_value,
  input  logic [learning_rate_size-1:0]     learning_rate,
  input  logic [backprop_controll_size-1:0] backprop_controll,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [data_size*size-1:0]         w_out,
  output logic [backprop_controll_size-1:0] backprop_controll_out,
  output logic                              busy
);
  localparam int cnt_w = (size > 1) ? $clog2(size) : 1;
  localparam logic [cnt_w-1:0]     last_lane = cnt_w'(size - 1);
  localparam logic [data_size-1:0] s_max     = {1'b0, {(data_size-1){1'b1}}};
  localparam logic [data_size-1:0] s_min     = {1'b1, {(data_size-1){1'b0}}};

  state_t                        state, state_nxt;
  logic [cnt_w-1:0]              lane;
  logic [data_size*size-1:0]     x_q, y_q, p_q;
  logic [learning_rate_size-1:0] lr_q;
  logic [data_size-1:0]          g_q, s_q;
  logic [data_size-1:0]          x_l, y_l, p_l, w_l, e, w_upd, mul_a, mul_b, mul_p;
  logic [data_size:0]            e_wide, w_wide;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    x_l    = x_q[data_size*lane +: data_size];
    y_l    = y_q[data_size*lane +: data_size];
    p_l    = p_q[data_size*lane +: data_size];
    w_l    = w_out[data_size*lane +: data_size];
    // One guard bit is enough to detect overflow of a two-operand subtraction.
    e_wide = {y_l[data_size-1], y_l} - {p_l[data_size-1], p_l};
    w_wide = {w_l[data_size-1], w_l} - {s_q[data_size-1], s_q};
    e      = (e_wide[data_size] != e_wide[data_size-1]) ?
             (e_wide[data_size] ? s_min : s_max) : e_wide[data_size-1:0];
    w_upd  = (w_wide[data_size] != w_wide[data_size-1]) ?
             (w_wide[data_size] ? s_min : s_max) : w_wide[data_size-1:0];
    mul_a  = (state == STEP) ? data_size'(lr_q) : e;
    mul_b  = (state == STEP) ? g_q : x_l;
  end

  fixed_mul_sat #(
    .data_size (data_size),
    .frac_bits (frac_bits)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = backprop_controll[BP_EN_BIT] ? ERR : DONE;
      ERR:     state_nxt = STEP;
      STEP:    state_nxt = UPD;
      UPD:     state_nxt = (lane == last_lane) ? DONE : ERR;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane                  <= '0;
      x_q                   <= '0;
      y_q                   <= '0;
      p_q                   <= '0;
      lr_q                  <= '0;
      g_q                   <= '0;
      s_q                   <= '0;
      w_out                 <= '0;
      backprop_controll_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          x_q                   <= x;
          y_q                   <= y;
          p_q                   <= predict_value;
          lr_q                  <= learning_rate;
          w_out                 <= w;
          backprop_controll_out <= backprop_controll;
          lane                  <= '0;
        end
        ERR:  g_q <= mul_p;
        STEP: s_q <= mul_p;
        UPD: begin
          w_out[data_size*lane +: data_size] <= w_upd;
          if (lane != last_lane) lane <= lane + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_weight_update.sv
// Directed bench with a scoreboard queue of expected weight/control/latency per accepted bundle.
module tb_dense_weight_update;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] w = '0, x = '0, y = '0, predict_value = '0;
  logic [15:0] learning_rate = '0;
  logic [65:0] backprop_controll = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] w_out;
  logic [65:0] backprop_controll_out;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [47:0] exp_w_q[$];
  logic [65:0] exp_bp_q[$];
  int          exp_lat_q[$];
  logic [47:0] last_w;
  logic [47:0] hold_w;
  logic [65:0] bp_v;

  dense_weight_update dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .w                     (w),
    .x                     (x),
    .y                     (y),
    .predict_value         (predict_value),
    .learning_rate         (learning_rate),
    .backprop_controll     (backprop_controll),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .w_out                 (w_out),
    .backprop_controll_out (backprop_controll_out),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  function automatic longint clamp(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [47:0] pk(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [47:0] model(input logic [47:0] wv, xv, yv, pv,
                                        input logic [15:0] lrv, input bit en);
    logic [47:0] r;
    longint wi, xi, yi, pi, lri, e, g, s;
    if (!en) return wv;
    lri = longint'($signed(lrv));
    for (int i = 0; i < N; i++) begin
      wi = longint'($signed(wv[16*i +: 16]));
      xi = longint'($signed(xv[16*i +: 16]));
      yi = longint'($signed(yv[16*i +: 16]));
      pi = longint'($signed(pv[16*i +: 16]));
      e  = clamp(yi - pi);
      g  = clamp((e * xi) >>> 8);
      s  = clamp((lri * g) >>> 8);
      r[16*i +: 16] = 16'(clamp(wi - s));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [47:0] wv, xv, yv, pv, input logic [15:0] lrv,
                          input logic [65:0] bpv);
    exp_w_q.push_back(model(wv, xv, yv, pv, lrv, bpv[0]));
    exp_bp_q.push_back(bpv);
    exp_lat_q.push_back(bpv[0] ? 3*N+1 : 1);
  endtask

  task automatic drive(input logic [47:0] wv, xv, yv, pv, input logic [15:0] lrv,
                       input logic [65:0] bpv);
    @(negedge clk);
    w = wv; x = xv; y = yv; predict_value = pv;
    learning_rate = lrv; backprop_controll = bpv; in_valid = 1'b1;
    chk("in_ready_at_accept", in_ready, 1'b1);
    push_exp(wv, xv, yv, pv, lrv, bpv);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input bit ack);
    int cycles;
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    assert (exp_w_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (exp_w_q.size() == 0) return;
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_latency"}, 66'(cycles), 66'(exp_lat_q.pop_front()));
    chk({tag, "_w_out"}, w_out, exp_w_q.pop_front());
    chk({tag, "_bp_out"}, backprop_controll_out, exp_bp_q.pop_front());
    last_w = w_out;
    if (ack) begin
      @(posedge clk); #1;
      chk({tag, "_out_valid_drop"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_w_out", w_out, 48'h0);
    chk("rst_bp_out", backprop_controll_out, 66'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic enabled update
    bp_v = {$urandom(), $urandom(), 2'b01};
    drive({3{16'd256}}, {3{16'd256}}, {3{16'd512}}, {3{16'd256}}, 16'd128, bp_v);
    collect("basic", 1'b1);
    chk("basic_lanes_128", last_w, {3{16'd128}});

    // Bypass
    bp_v = {$urandom(), $urandom(), 2'b10};
    drive({16'h7FFF, 16'h8000, 16'h0123}, 48'h1, 48'h2, 48'h3, 16'h100, bp_v);
    collect("bypass", 1'b1);
    chk("bypass_identity", last_w, {16'h7FFF, 16'h8000, 16'h0123});

    // Saturation, both directions
    drive({3{16'h7FFF}}, {3{16'h7FFF}}, {3{16'h8000}}, {3{16'h7FFF}}, 16'h7FFF, 66'h1);
    collect("sat_hi", 1'b1);
    chk("sat_hi_lit", last_w, {3{16'h7FFF}});
    drive({3{16'h8000}}, {3{16'h7FFF}}, {3{16'h7FFF}}, {3{16'h8000}}, 16'h7FFF, 66'h3);
    collect("sat_lo", 1'b1);
    chk("sat_lo_lit", last_w, {3{16'h8000}});

    // Back-pressure with a pending bundle that must wait
    out_ready = 1'b0;
    drive(pk(100, -50, 7), pk(256, 512, -256), pk(300, 0, 10), pk(200, 256, -10), 16'd64, 66'h5);
    collect("bp_a", 1'b0);
    hold_w = model(pk(100, -50, 7), pk(256, 512, -256), pk(300, 0, 10), pk(200, 256, -10),
                   16'd64, 1'b1);
    @(negedge clk);
    w = pk(1000, 2000, -3000); x = pk(128, 128, 128); y = pk(512, -512, 0);
    predict_value = pk(0, 0, 256); learning_rate = 16'd256; backprop_controll = 66'h9;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_w_out", w_out, hold_w);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    push_exp(w, x, y, predict_value, learning_rate, backprop_controll);
    @(posedge clk); #1;
    chk("release_out_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pending_accepted_busy", busy, 1'b1);
    collect("bp_b", 1'b1);

    // Reset during STEP of lane 1
    drive(pk(5, 6, 7), pk(256, 256, 256), pk(512, 512, 512), pk(0, 0, 0), 16'd256, 66'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_w_out", w_out, 48'h0);
    chk("abort_bp_out", backprop_controll_out, 66'h0);
    chk("abort_busy", busy, 1'b0);
    void'(exp_w_q.pop_back());
    void'(exp_bp_q.pop_back());
    void'(exp_lat_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    drive(pk(-100, 300, 0), pk(256, -128, 64), pk(256, 256, -256), pk(0, 512, 256),
          16'd200, 66'h2_0000_0000_0000_0001);
    collect("post_reset", 1'b1);

    // Per-lane independence
    drive(pk(0, 0, 0), pk(256, 256, 256), pk(512, 256, 256), pk(256, 512, 256), 16'd256, 66'h1);
    collect("lanes", 1'b1);
    chk("lanes_lit", last_w, pk(-256, 256, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
